// File: rtl/uart_alu_top.sv
// UART-attached packet ALU: 8N1 receiver, packet decoder (echo / 32-bit add),
// 4-entry response FIFO and 8N1 transmitter, all in one clock domain.
module uart_alu_top #(
    parameter int PRESCALE   = 410,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic RX_i,
    output logic TX_o
);
    localparam int DW       = DATA_WIDTH;
    localparam int LW       = 2 * DW;
    localparam int AW       = 4 * DW;
    localparam int BIT_CLKS = 8 * PRESCALE;
    localparam int CW       = $clog2(BIT_CLKS) + 1;
    localparam int BW       = (DW > 1) ? $clog2(DW) : 1;
    localparam int TW       = $clog2(DW + 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(4 * PRESCALE - 1);
    localparam logic [DW-1:0] OP_ADD    = DW'(8'h01);
    localparam logic [DW-1:0] OP_ECHO   = DW'(8'hEC);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_HDR, P_PAYLOAD, P_RESULT} pkt_state_t;

    // ---------------- receiver ----------------
    logic [2:0]    rx_sync_q;
    logic          rx_s, rx_fall;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0] rx_bit_q, rx_bit_d;
    logic [DW-1:0] rx_shift_q, rx_shift_d;
    logic [DW-1:0] rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;

    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) rx_sync_q <= '1;
        else         rx_sync_q <= {rx_sync_q[1:0], RX_i};
    end

    // Receiver next state: glitch check at half bit, then sample at bit centres.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[DW-1:1]};
                    if (rx_bit_q == BW'(DW - 1)) rx_state_d = R_STOP;
                    else                         rx_bit_d   = rx_bit_q + BW'(1);
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    // A low stop bit is a framing error: the byte is dropped.
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_shift_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ---------------- response FIFO ----------------
    logic [DW-1:0] fifo_mem_q [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    fifo_cnt_q;
    logic          fifo_full, push, push_en, tx_pop;
    logic [DW-1:0] push_data;
    logic          tx_busy_q;

    assign fifo_full = (fifo_cnt_q == 3'd4);
    assign push_en   = push & ~fifo_full;
    assign tx_pop    = ~tx_busy_q & (fifo_cnt_q != 3'd0);

    // FIFO storage; contents need no reset because the count gates reads.
    always_ff @(posedge clk_i) begin
        if (push_en) fifo_mem_q[wr_ptr_q] <= push_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push_en, tx_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ---------------- packet control ----------------
    pkt_state_t    p_state_q, p_state_d;
    logic [DW-1:0] opcode_q, opcode_d;
    logic [DW-1:0] len_lsb_q, len_lsb_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [3*DW-1:0] opnd_q, opnd_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [1:0]    res_idx_q, res_idx_d;

    // Packet FSM: header parse, payload echo/accumulate, result push.
    always_comb begin
        p_state_d = p_state_q;
        opcode_d  = opcode_q;
        len_lsb_d = len_lsb_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        res_idx_d = res_idx_q;
        push      = 1'b0;
        push_data = rx_byte_q;
        case (p_state_q)
            P_IDLE: begin
                if (rx_valid_q) begin
                    opcode_d  = rx_byte_q;
                    cnt_d     = LW'(1);
                    acc_d     = '0;
                    p_state_d = P_HDR;
                end
            end
            P_HDR: begin
                if (rx_valid_q) begin
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q == LW'(2)) len_lsb_d = rx_byte_q;
                    if (cnt_q == LW'(3)) begin
                        len_d     = {rx_byte_q, len_lsb_q};
                        res_idx_d = '0;
                        if ({rx_byte_q, len_lsb_q} <= LW'(4))
                            p_state_d = (opcode_q == OP_ADD) ? P_RESULT : P_IDLE;
                        else
                            p_state_d = P_PAYLOAD;
                    end
                end
            end
            P_PAYLOAD: begin
                if (rx_valid_q) begin
                    cnt_d = cnt_q + LW'(1);
                    if (opcode_q == OP_ECHO) push = 1'b1;
                    // Payload starts at byte 4, so cnt[1:0] is the lane within the operand.
                    if (opcode_q == OP_ADD) begin
                        case (cnt_q[1:0])
                            2'd0:    opnd_d[DW-1:0]      = rx_byte_q;
                            2'd1:    opnd_d[2*DW-1:DW]   = rx_byte_q;
                            2'd2:    opnd_d[3*DW-1:2*DW] = rx_byte_q;
                            default: acc_d = acc_q + {rx_byte_q, opnd_q};
                        endcase
                    end
                    if (cnt_q + LW'(1) == len_q)
                        p_state_d = (opcode_q == OP_ADD) ? P_RESULT : P_IDLE;
                end
            end
            default: begin
                push = 1'b1;
                case (res_idx_q)
                    2'd0:    push_data = acc_q[DW-1:0];
                    2'd1:    push_data = acc_q[2*DW-1:DW];
                    2'd2:    push_data = acc_q[3*DW-1:2*DW];
                    default: push_data = acc_q[4*DW-1:3*DW];
                endcase
                // Result bytes are never dropped; wait for space instead.
                if (!fifo_full) begin
                    res_idx_d = res_idx_q + 2'd1;
                    if (res_idx_q == 2'd3) p_state_d = P_IDLE;
                end
            end
        endcase
    end

    // Packet FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            p_state_q <= P_IDLE;
            opcode_q  <= '0;
            len_lsb_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            res_idx_q <= '0;
        end else begin
            p_state_q <= p_state_d;
            opcode_q  <= opcode_d;
            len_lsb_q <= len_lsb_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            res_idx_q <= res_idx_d;
        end
    end

    // ---------------- transmitter ----------------
    logic [CW-1:0] tx_cnt_q;
    logic [TW-1:0] tx_bit_q;
    logic [DW:0]   tx_shift_q;
    logic          tx_q;

    assign TX_o = tx_q;

    // Transmitter: start bit on load, then data LSB first, then the stop bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_q       <= 1'b1;
        end else if (tx_pop) begin
            tx_busy_q  <= 1'b1;
            tx_q       <= 1'b0;
            tx_shift_q <= {1'b1, fifo_mem_q[rd_ptr_q]};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == TW'(DW + 1)) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[DW:1]};
                    tx_bit_q   <= tx_bit_q + TW'(1);
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_alu_top.sv
// Directed bench for uart_alu_top: drives 8N1 packets on RX, decodes TX.
module tb_uart_alu_top;
    localparam int PRESCALE = 1;
    localparam int BIT      = 8 * PRESCALE;
    localparam int HALF     = 4 * PRESCALE;
    // Allowed start-bit delay from stop-bit centre: 4 clocks plus synchroniser slack.
    localparam int LAT_MAX  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    always #5 clk = ~clk;

    uart_alu_top #(.PRESCALE(PRESCALE), .DATA_WIDTH(8)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .RX_i   (rx),
        .TX_o   (tx)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  pkt[$];
    logic [31:0] ops[8];
    logic [7:0]  mon_b;
    int          lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // TX line decoder: finds start bits and samples at bit centres.
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (HALF) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        mon_b[i] = tx;
                    end
                    repeat (BIT) @(negedge clk);
                    if (tx === 1'b1) rxq.push_back(mon_b);
                end
            end
        end
    end

    function automatic logic [7:0] q_at(input int i);
        if (i < rxq.size()) return rxq[i];
        return 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit measure);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        if (measure) begin
            repeat (HALF) @(negedge clk);
            lat = 99;
            for (int i = 1; i <= 2 * BIT; i++) begin
                @(negedge clk);
                if (tx === 1'b0) begin
                    lat = i;
                    break;
                end
            end
            check("first_result_latency_ok", 32'(lat <= LAT_MAX), 32'd1);
        end else begin
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_pkt(input bit measure);
        for (int i = 0; i < pkt.size(); i++)
            send_byte(pkt[i], measure && (i == pkt.size() - 1));
    endtask

    task automatic build_add(input int n);
        pkt.delete();
        pkt.push_back(8'h01);
        pkt.push_back(8'h00);
        pkt.push_back(8'(4 + 4 * n));
        pkt.push_back(8'h00);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++)
                pkt.push_back(ops[k][8*j +: 8]);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int c = 0;
        while (rxq.size() < n && c < 60 * BIT) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_byte_count"}, 32'(rxq.size()), 32'(n));
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w);
        wait_bytes(4, tag);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s_b%0d", tag, j), {24'h0, q_at(j)}, {24'h0, w[8*j +: 8]});
        $display("pkt %s: tx bytes %02h %02h %02h %02h", tag, q_at(0), q_at(1), q_at(2), q_at(3));
    endtask

    task automatic settle(input string tag, input int n);
        repeat (12 * BIT) @(negedge clk);
        check({tag, "_no_extra"}, 32'(rxq.size()), 32'(n));
        check({tag, "_tx_idle"}, {31'h0, tx}, 32'd1);
        rxq.delete();
    endtask

    logic [7:0]  echo_v [8] = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0]  unk_v  [8] = '{8'h55, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] sum;
    int          nops;
    int          c;

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("reset_tx_high", {31'h0, tx}, 32'd1);
        rst = 1'b0;
        repeat (4 * BIT) @(negedge clk);
        check("reset_no_output", 32'(rxq.size()), 32'd0);

        // Add 1 + 2
        ops[0] = 32'h1; ops[1] = 32'h2;
        build_add(2); send_pkt(1'b1);
        expect_word("add_1_2", 32'h0000_0003);
        settle("add_1_2", 4);

        // Add with wrap: carry discarded
        ops[0] = 32'hFFFF_FFFF; ops[1] = 32'h2;
        build_add(2); send_pkt(1'b1);
        expect_word("add_wrap", 32'h0000_0001);
        settle("add_wrap", 4);

        // Zero operands (length 4)
        build_add(0); send_pkt(1'b0);
        expect_word("add_zero", 32'h0000_0000);
        settle("add_zero", 4);

        // Echo payload only
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(echo_v[i]);
        send_pkt(1'b0);
        expect_word("echo", 32'hEFBE_ADDE);
        settle("echo", 4);

        // Fuzz: 2-5 random operands per packet
        for (int p = 0; p < 20; p++) begin
            nops = $urandom_range(2, 5);
            sum = 32'h0;
            for (int k = 0; k < nops; k++) begin
                ops[k] = $urandom;
                sum = sum + ops[k];
            end
            build_add(nops); send_pkt(1'b0);
            wait_bytes(4, "fuzz");
            check($sformatf("fuzz%0d_sum", p), {q_at(3), q_at(2), q_at(1), q_at(0)}, sum);
            $display("pkt fuzz%0d: %0d operands, word %02h%02h%02h%02h", p, nops,
                     q_at(3), q_at(2), q_at(1), q_at(0));
            rxq.delete();
        end
        repeat (12 * BIT) @(negedge clk);
        rxq.delete();

        // Reset mid-packet while TX is sending a result
        ops[0] = 32'h11; ops[1] = 32'h22;
        build_add(2); send_pkt(1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h0C, 1'b0);
        c = 0;
        while (tx !== 1'b0 && c < 20 * BIT) begin
            @(negedge clk);
            c++;
        end
        check("tx_low_before_reset", {31'h0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1 check("reset_tx_immediate", {31'h0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15 * BIT) @(negedge clk);
        rxq.delete();
        ops[0] = 32'h5; ops[1] = 32'h7;
        build_add(2); send_pkt(1'b1);
        expect_word("after_reset_add", 32'h0000_000C);
        settle("after_reset_add", 4);

        // Unknown opcode is silent; following add answers
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(unk_v[i]);
        send_pkt(1'b0);
        ops[0] = 32'd10; ops[1] = 32'd20;
        build_add(2); send_pkt(1'b0);
        expect_word("unknown_then_add", 32'h0000_001E);
        settle("unknown_then_add", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
